// File: rtl/mult_share_ctrl.sv
// Round-robin arbiter and sequencer for the shared shift-add multiplier datapath.
// Grants one of two requesters, steps the datapath through WIDTH add/shift iterations, then acks.
module mult_share_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic [WIDTH-1:0]     mcand,
  output logic [WIDTH-1:0]     mplier,
  output logic                 lm,
  output logic                 lp,
  output logic                 add_en,
  output logic                 sm,
  input  logic                 dp_lsb,
  input  logic [2*WIDTH-1:0]   dp_product
);

  typedef enum logic [2:0] {IDLE, LOAD, TEST, SHIFT, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 last_q, last_d;
  logic                 gnt_q, gnt_d;
  logic                 ack0_q, ack0_d;
  logic                 ack1_q, ack1_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 grant_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      result_q <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      result_q <= result_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    result_d  = result_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    grant_sel = 1'b0;
    lm        = 1'b0;
    lp        = 1'b0;
    add_en    = 1'b0;
    sm        = 1'b0;

    case (state_q)
      IDLE: begin
        // An ack cycle never grants, so a requester can drop req off its ack.
        if ((req0 || req1) && !ack0_q && !ack1_q) begin
          grant_sel = (req0 && req1) ? ~last_q : req1;
          gnt_d     = grant_sel;
          mcand_d   = grant_sel ? a1 : a0;
          mplier_d  = grant_sel ? b1 : b0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        lm      = 1'b1;
        lp      = 1'b1;
        cnt_d   = '0;
        state_d = TEST;
      end
      TEST: begin
        add_en  = dp_lsb;
        state_d = SHIFT;
      end
      SHIFT: begin
        sm = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = TEST;
        end
      end
      DONE: begin
        result_d = dp_product;
        ack0_d   = ~gnt_q;
        ack1_d   = gnt_q;
        last_d   = gnt_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign result = result_q;
  assign mcand  = mcand_q;
  assign mplier = mplier_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl with a behavioural shift-add datapath model.
module tb_mult_share_ctrl;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               req0 = 1'b0, req1 = 1'b0;
  logic [WIDTH-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic               ack0, ack1, busy, lm, lp, add_en, sm;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   mcand, mplier;
  logic               dp_lsb;
  logic [2*WIDTH-1:0] dp_product;

  int tests = 0;
  int failed = 0;
  int sm_cnt = 0;
  int add_cnt = 0;
  int n, port, sm_snap, add_snap, seen, busy_seen;

  logic [2*WIDTH:0]   p_reg = '0;
  logic [WIDTH-1:0]   m_reg = '0;

  always #5 clk = ~clk;

  mult_share_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .result(result), .busy(busy),
    .mcand(mcand), .mplier(mplier),
    .lm(lm), .lp(lp), .add_en(add_en), .sm(sm),
    .dp_lsb(dp_lsb), .dp_product(dp_product)
  );

  // Datapath model: bit 2*WIDTH holds the adder carry until the following shift.
  always @(posedge clk) begin
    if (lm) m_reg <= mcand;
    if (lp) p_reg <= {1'b0, {WIDTH{1'b0}}, mplier};
    else if (add_en) p_reg[2*WIDTH:WIDTH] <= {1'b0, p_reg[2*WIDTH-1:WIDTH]} + {1'b0, m_reg};
    else if (sm) p_reg <= p_reg >> 1;
  end
  assign dp_lsb     = p_reg[0];
  assign dp_product = p_reg[2*WIDTH-1:0];

  always @(negedge clk) begin
    if (sm === 1'b1) sm_cnt++;
    if (add_en === 1'b1) add_cnt++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits for an ack; optionally scrambles port-0 operands or drops req1 after drop_at cycles.
  task automatic run_until_ack(input int max_n, input bit scramble, input int drop_at,
                               output int n_out, output int port_out);
    n_out = 0;
    port_out = -1;
    while (n_out < max_n) begin
      @(negedge clk);
      n_out++;
      if (ack0) begin port_out = 0; break; end
      if (ack1) begin port_out = 1; break; end
      if (scramble) begin a0 = $urandom; b0 = $urandom; end
      if (drop_at == n_out) req1 = 1'b0;
    end
  endtask

  initial begin
    // Reset values
    #2 reset = 1'b1;
    @(negedge clk);
    check_output("rst_acks", {62'd0, ack0, ack1}, 64'd0);
    check_output("rst_strobes", {59'd0, busy, lm, lp, add_en, sm}, 64'd0);
    check_output("rst_result", result, 64'd0);
    check_output("rst_operands", {mcand, mplier}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single op 3*5
    a0 = 32'd3; b0 = 32'd5; req0 = 1'b1;
    sm_snap = sm_cnt; add_snap = add_cnt;
    @(negedge clk);
    check_output("load_strobes", {59'd0, busy, lm, lp, add_en, sm}, 64'b11100);
    check_output("load_operands", {mcand, mplier}, {32'd3, 32'd5});
    run_until_ack(80, 1'b0, 0, n, port);
    req0 = 1'b0;
    check_output("single_port", 64'(port), 64'd0);
    check_output("single_latency", 64'(n + 1), 64'd67);
    check_output("single_result", result, 64'd15);
    check_output("single_sm_pulses", 64'(sm_cnt - sm_snap), 64'd32);
    check_output("single_add_pulses", 64'(add_cnt - add_snap), 64'd2);
    @(negedge clk);
    check_output("single_ack_pulse", {61'd0, ack0, ack1, busy}, 64'd0);
    check_output("single_result_hold", result, 64'd15);

    // Tie from reset: port 0 wins first
    reset = 1'b1;
    a0 = 32'd7; b0 = 32'd9; a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF;
    req0 = 1'b1; req1 = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_until_ack(80, 1'b0, 0, n, port);
    req0 = 1'b0;
    check_output("tie_first_port", 64'(port), 64'd0);
    check_output("tie_first_latency", 64'(n), 64'd67);
    check_output("tie_first_result", result, 64'd63);
    run_until_ack(80, 1'b0, 0, n, port);
    req1 = 1'b0;
    check_output("tie_second_port", 64'(port), 64'd1);
    check_output("tie_second_spacing", 64'(n), 64'd68);
    check_output("tie_second_result", result, 64'hFFFF_FFFE_0000_0001);

    // Fairness with both requests held
    reset = 1'b1;
    a0 = 32'd2; b0 = 32'd3; a1 = 32'd4; b1 = 32'd5;
    req0 = 1'b1; req1 = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_until_ack(80, 1'b0, 0, n, port);
      check_output($sformatf("fair_port_%0d", i), 64'(port), 64'(i % 2));
      check_output($sformatf("fair_result_%0d", i), result, (i % 2 == 0) ? 64'd6 : 64'd20);
      check_output($sformatf("fair_latency_%0d", i), 64'(n), (i == 0) ? 64'd67 : 64'd68);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    // Operand stability: port-0 operands scrambled every cycle after grant
    a0 = 32'h1234; b0 = 32'h10; req0 = 1'b1;
    run_until_ack(80, 1'b1, 0, n, port);
    req0 = 1'b0;
    check_output("stable_port", 64'(port), 64'd0);
    check_output("stable_result", result, 64'h12340);
    @(negedge clk);

    // Zero multiplicand keeps the fixed latency
    a0 = 32'd0; b0 = 32'hDEAD_BEEF; req0 = 1'b1;
    sm_snap = sm_cnt; add_snap = add_cnt;
    run_until_ack(80, 1'b0, 0, n, port);
    req0 = 1'b0;
    check_output("zero_latency", 64'(n), 64'd67);
    check_output("zero_result", result, 64'd0);
    check_output("zero_sm_pulses", 64'(sm_cnt - sm_snap), 64'd32);
    check_output("zero_add_pulses", 64'(add_cnt - add_snap), 64'd24);
    @(negedge clk);

    // Reset during the 10th SHIFT
    a0 = 32'd3; b0 = 32'd5; req0 = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && seen < 10; i++) begin
      @(negedge clk);
      if (sm) seen++;
    end
    check_output("midrst_reached_shift10", 64'(seen), 64'd10);
    reset = 1'b1;
    #1;
    check_output("midrst_acks", {62'd0, ack0, ack1}, 64'd0);
    check_output("midrst_strobes", {59'd0, busy, lm, lp, add_en, sm}, 64'd0);
    check_output("midrst_result", result, 64'd0);
    check_output("midrst_operands", {mcand, mplier}, 64'd0);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 75; i++) begin
      @(negedge clk);
      if (ack0 || ack1) seen++;
    end
    check_output("midrst_no_ack", 64'(seen), 64'd0);
    a0 = 32'd11; b0 = 32'd13; req0 = 1'b1;
    run_until_ack(80, 1'b0, 0, n, port);
    req0 = 1'b0;
    check_output("postrst_port", 64'(port), 64'd0);
    check_output("postrst_latency", 64'(n), 64'd67);
    check_output("postrst_result", result, 64'd143);
    @(negedge clk);

    // req1 dropped five cycles after grant
    a1 = 32'd100; b1 = 32'd200; req1 = 1'b1;
    run_until_ack(80, 1'b0, 5, n, port);
    check_output("drop_port", 64'(port), 64'd1);
    check_output("drop_latency", 64'(n), 64'd67);
    check_output("drop_result", result, 64'd20000);
    seen = 0; busy_seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (ack0 || ack1) seen++;
      if (busy) busy_seen++;
    end
    check_output("drop_no_regrant", 64'(busy_seen), 64'd0);
    check_output("drop_no_extra_ack", 64'(seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
